// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: format codes, field widths, opcodes
// and the field-packing function used ahead of the output buffer.
package instr_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JT_W    = 26;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  localparam logic [OP_W-1:0]   OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0]   OP_J     = 6'h02;
  localparam logic [OP_W-1:0]   OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0]   OP_LW    = 6'h23;
  localparam logic [FUNC_W-1:0] FUNC_ADD = 6'h20;

  function automatic logic [31:0] encode(
    input fmt_e               f,
    input logic [OP_W-1:0]    op,
    input logic [REG_W-1:0]   rs,
    input logic [REG_W-1:0]   rt,
    input logic [REG_W-1:0]   rd,
    input logic [SHAMT_W-1:0] sh,
    input logic [FUNC_W-1:0]  fn,
    input logic [IMM_W-1:0]   imm,
    input logic [JT_W-1:0]    jt
  );
    logic [31:0] w;
    w = '0;
    case (f)
      FMT_R:   w = {op, rs, rt, rd, sh, fn};
      FMT_I:   w = {op, rs, rt, imm};
      FMT_J:   w = {op, jt};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two circular buffer with synchronous flush; the read port shows
// zero while empty so nothing stale is ever presented.
module instr_fifo #(
  parameter int unsigned width = 40,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(depth));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_enc.sv
// Instruction encoder: packs R/I/J field bundles into words and queues them
// with consecutive word addresses for the instruction-memory writer.
module instr_enc
  import instr_pkg::*;
#(
  parameter int unsigned WL    = 32,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [OP_W-1:0]          OPcode,
  input  logic [FUNC_W-1:0]        Func,
  input  logic [REG_W-1:0]         RS,
  input  logic [REG_W-1:0]         RT,
  input  logic [REG_W-1:0]         RD,
  input  logic [SHAMT_W-1:0]       shamt,
  input  logic [IMM_W-1:0]         Imm,
  input  logic [JT_W-1:0]          Jumpt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WL-1:0]            out_word,
  output logic [AW-1:0]            out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_fmt
);

  localparam int unsigned EW = AW + WL;

  logic          rdy_q, err_q;
  logic [AW-1:0] addr_q;
  logic [WL-1:0] enc_word;
  logic [EW-1:0] rdata;
  logic          full, empty;
  logic          accept, legal, push;

  // rdy_q holds in_ready low through reset and raises it on the first edge after.
  assign in_ready = rdy_q & ~full;
  assign accept   = in_valid & in_ready;
  assign legal    = (fmt_e'(fmt) != FMT_BAD);
  assign push     = accept & legal & ~clr;

  always_comb begin
    enc_word = '0;
    enc_word = encode(fmt_e'(fmt), OPcode, RS, RT, RD, shamt, Func, Imm, Jumpt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      err_q <= accept & ~legal & ~clr;
      if (clr)       addr_q <= '0;
      else if (push) addr_q <= addr_q + 1'b1;
    end
  end

  instr_fifo #(
    .width (EW),
    .depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (out_ready),
    .wdata ({addr_q, enc_word}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid             = ~empty;
  assign {out_addr, out_word}  = rdata;
  assign err_fmt               = err_q;

endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc (AW=2 so address wrap is reachable quickly).
module tb_instr_enc;

  logic        clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready, err_fmt;
  logic [1:0]  fmt;
  logic [5:0]  OPcode, Func;
  logic [4:0]  RS, RT, RD, shamt;
  logic [15:0] Imm;
  logic [25:0] Jumpt;
  logic [31:0] out_word;
  logic [1:0]  out_addr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  instr_enc #(.WL(32), .AW(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .OPcode    (OPcode),
    .Func      (Func),
    .RS        (RS),
    .RT        (RT),
    .RD        (RD),
    .shamt     (shamt),
    .Imm       (Imm),
    .Jumpt     (Jumpt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .count     (count),
    .err_fmt   (err_fmt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] jt);
    in_valid = 1'b1;
    fmt = f; OPcode = op; RS = rs; RT = rt; RD = rd; shamt = sh; Func = fn;
    Imm = imm; Jumpt = jt;
  endtask

  task automatic drive_j(input logic [25:0] jt);
    drive(2'd2, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, jt);
  endtask

  task automatic pop_check(input string tag, input logic [1:0] ea, input logic [31:0] ew);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_word"}, out_word, ew);
    check({tag, "_addr"}, {30'd0, out_addr}, {30'd0, ea});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic flush();
    in_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(2'd0, 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 6'h0, 16'h0, 26'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_err", {31'd0, err_fmt}, 32'd0);
    check("rst_word", out_word, 32'd0);
    check("rst_addr", {30'd0, out_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // R-type with one-cycle latency
    drive(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hdead, 26'h3ffffff);
    check("r_no_early_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    pop_check("r_type", 2'd0, 32'h00221820);
    check("r_drained", {31'd0, out_valid}, 32'd0);

    // I then J, with unused fields driven to junk
    flush();
    drive(2'd1, 6'h08, 5'd1, 5'd2, 5'h1f, 5'h1f, 6'h3f, 16'h0005, 26'h3ffffff);
    tick();
    drive(2'd2, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h0000010);
    tick();
    in_valid = 1'b0;
    check("ij_count", {29'd0, count}, 32'd2);
    pop_check("i_type", 2'd0, 32'h20220005);
    pop_check("j_type", 2'd1, 32'h08000010);

    // Illegal format between two legal bundles
    flush();
    drive(2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hfffc, 26'd0);
    tick();
    check("err_idle", {31'd0, err_fmt}, 32'd0);
    drive(2'd3, 6'h3f, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
    tick();
    check("err_pulse", {31'd0, err_fmt}, 32'd1);
    drive_j(26'h0000abc);
    tick();
    check("err_one_cycle", {31'd0, err_fmt}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("err_stays_low", {31'd0, err_fmt}, 32'd0);
    check("bad_no_push", {29'd0, count}, 32'd2);
    pop_check("lw_after_bad", 2'd0, 32'h8fa8fffc);
    pop_check("j_after_bad", 2'd1, 32'h08000abc);

    // clr suppresses err_fmt for an illegal bundle in the same cycle
    drive(2'd3, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_suppress_err", {31'd0, err_fmt}, 32'd0);

    // Backpressure: five offered, four accepted
    flush();
    for (int i = 0; i < 5; i++) begin
      drive_j(26'(i));
      tick();
    end
    in_valid = 1'b0;
    check("bp_count_full", {29'd0, count}, 32'd4);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    pop_check("bp_head0", 2'd0, 32'h08000000);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    // push and pop together: count holds, order preserved
    check("bp_head1_word", out_word, 32'h08000001);
    drive_j(26'h100);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_pushpop_count", {29'd0, count}, 32'd3);
    pop_check("bp_head2", 2'd2, 32'h08000002);
    pop_check("bp_head3", 2'd3, 32'h08000003);
    pop_check("bp_wrapped", 2'd0, 32'h08000100);
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    // out_ready while empty has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_pop_ignored", {29'd0, count}, 32'd0);

    // Address wrap with streaming output
    flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_j(26'(32 + i));
      tick();
      check($sformatf("wrap_addr%0d", i), {30'd0, out_addr}, 32'(i % 4));
      check($sformatf("wrap_word%0d", i), out_word, 32'h08000020 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("wrap_drained", {29'd0, count}, 32'd0);

    // Flush with a concurrent bundle
    flush();
    for (int i = 0; i < 3; i++) begin
      drive_j(26'(i));
      tick();
    end
    check("flush_pre_count", {29'd0, count}, 32'd3);
    drive_j(26'h3);
    clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("flush_discarded", {29'd0, count}, 32'd0);
    drive_j(26'h55);
    tick();
    in_valid = 1'b0;
    pop_check("flush_addr_zero", 2'd0, 32'h08000055);

    // Asynchronous reset mid-stream
    drive_j(26'h7);
    tick();
    drive_j(26'h8);
    tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", {29'd0, count}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_word", out_word, 32'd0);
    check("arst_addr", {30'd0, out_addr}, 32'd0);
    check("arst_err", {31'd0, err_fmt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("arst_ready_back", {31'd0, in_ready}, 32'd1);
    check("arst_no_residue", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
